pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage in-order pipeline.
- Collects the decode load-use stall request, the EX redirect, and I-cache/D-cache miss handshakes.
- Drives per-stage stall/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Tracks multi-cycle miss waits with an FSM, a kill flag for stale fetches, and a watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024, miss-wait cycles before miss_timeout sets.
- TO_CNT_WIDTH, 11, watchdog counter width; must satisfy 2^TO_CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- hz_stall_req  input  1  load-use stall request from decode hazard unit
- ex_redirect  input  1  taken branch/jump mispredict resolved in EX
- icache_miss  input  1  fetch missed this cycle (one-cycle pulse)
- icache_ready  input  1  refill done; level, held by I-cache until controller leaves I_WAIT
- dcache_miss  input  1  MEM access missed this cycle (pulse)
- dcache_ready  input  1  D-cache refill done (pulse)
- pc_stall  output  1  hold PC
- pc_redirect_en  output  1  PC loads EX target
- ifid_stall, ifid_flush  output  1 each  IF/ID hold / bubble
- idex_stall, idex_flush  output  1 each  ID/EX hold / bubble
- exmem_stall  output  1  EX/MEM hold
- memwb_flush  output  1  MEM/WB bubble
- miss_timeout  output  1  sticky watchdog error
- ctrl_state  output  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, I_WAIT=1, D_WAIT=2. Registers: state, ret_state, kill_pending, watchdog count, miss_timeout.
- Reset (rst_n=0 at clk edge): state=RUN, ret_state=RUN, kill_pending=0, count=0, miss_timeout=0.
- While rst_n=0, outputs are forced: all *_stall=0, pc_redirect_en=0, ifid_flush=idex_flush=memwb_flush=1. Reset mid-miss abandons the wait.
- Outputs are combinational from state and inputs (same-cycle effect). Evaluate in this priority order; unlisted outputs are 0.
- P1, freeze (state==D_WAIT, or RUN/I_WAIT with dcache_miss): pc_stall, ifid_stall, idex_stall, exmem_stall=1; memwb_flush=1. ex_redirect and hz_stall_req are ignored; EX holds them stable until release.
- P2, redirect (ex_redirect): pc_redirect_en=1; ifid_flush=1; idex_flush=1; pc_stall=0. This overrides a simultaneous load-use request.
- P3, load-use (hz_stall_req): pc_stall=1, ifid_stall=1, idex_flush=1. ifid_flush=0 even in I_WAIT.
- P4, fetch bubble (state==I_WAIT without icache_ready, or RUN with icache_miss): pc_stall=1, ifid_flush=1.
- I_WAIT with icache_ready and kill_pending=1: ifid_flush=1, so the stale line is discarded.
- Transitions from RUN:
  - dcache_miss -> D_WAIT, ret_state=RUN.
  - else icache_miss -> I_WAIT; kill_pending=ex_redirect.
- Transitions from I_WAIT:
  - dcache_miss -> D_WAIT, ret_state=I_WAIT.
  - else icache_ready -> RUN, kill_pending cleared.
  - ex_redirect in I_WAIT (not frozen) sets kill_pending.
- Transitions from D_WAIT:
  - dcache_ready -> ret_state. The release cycle still shows freeze outputs.
  - Next cycle, if ret_state was I_WAIT and icache_ready is already high, exit to RUN as usual.
- Watchdog: count increments each cycle state!=RUN and saturates; it clears in RUN. When count==TIMEOUT_CYCLES-1 and still waiting, miss_timeout=1 next edge; it stays set until reset.
- Simultaneous dcache_miss and icache_miss in RUN: D_WAIT with ret_state=RUN. The I-cache re-raises its miss after release.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_lu_cycles, perf_imiss_cycles, perf_dmiss_cycles, perf_redirects.
  - Each counts cycles in which P3, P4, P1 (respectively) is active, or P2 events.
  - Counters wrap modulo 2^32 and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared Define.v: PC_ST_RUN/PC_ST_I_WAIT/PC_ST_D_WAIT and PC_ST_WIDTH=2.
- Sub-module pipe_ctrl_wdog: counter, saturation and sticky miss_timeout, with inputs clk, rst_n, active.

Test Plan:
- Load-use: hz_stall_req=1 for 1 cycle in RUN -> pc_stall=ifid_stall=idex_flush=1 that cycle only; state stays 0.
- Redirect + load-use same cycle -> pc_redirect_en=1, ifid_flush=idex_flush=1, pc_stall=0.
- dcache_miss at cycle 10, dcache_ready at cycle 20:
  - cycles 10-20: four stalls=1 and memwb_flush=1.
  - cycle 21: all 0, ctrl_state=0.
- icache_miss at cycle 5, ex_redirect at cycle 7, icache_ready held from cycle 12:
  - pc_redirect_en=1 at 7.
  - ifid_flush=1 at cycles 5-12.
  - RUN at 13 with kill_pending=0.
- I_WAIT then dcache_miss then dcache_ready -> ctrl_state 1->2->1; with icache_ready high, RUN one cycle later.
- TIMEOUT_CYCLES=8, D_WAIT held 20 cycles -> miss_timeout rises after 8 wait cycles, stays 1 after return to RUN, clears only on rst_n=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// State encoding shared by the pipeline stall/flush sequencer and its bench.
package pipe_ctrl_pkg;

   localparam int unsigned PcStWidth = 2;

   typedef enum logic [PcStWidth-1:0] {
      PcStRun   = 2'd0,
      PcStIWait = 2'd1,
      PcStDWait = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Miss-wait watchdog: saturating wait counter and a sticky timeout flag.
module pipe_ctrl_wdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TO_CNT_WIDTH   = 11
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   output logic miss_timeout
);

   localparam logic [TO_CNT_WIDTH-1:0] LastCnt = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TO_CNT_WIDTH-1:0] count_q, count_d;
   logic                    timeout_q, timeout_d;

   always_comb begin
      count_d   = count_q;
      timeout_d = timeout_q;
      if (!active) begin
         count_d = '0;
      end else begin
         if (count_q != '1) count_d = count_q + TO_CNT_WIDTH'(1);
         if (count_q == LastCnt) timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         timeout_q <= timeout_d;
      end
   end

   assign miss_timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirect and cache-miss waits.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned TO_CNT_WIDTH   = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 hz_stall_req,
   input  logic                 ex_redirect,
   input  logic                 icache_miss,
   input  logic                 icache_ready,
   input  logic                 dcache_miss,
   input  logic                 dcache_ready,
   output logic                 pc_stall,
   output logic                 pc_redirect_en,
   output logic                 ifid_stall,
   output logic                 ifid_flush,
   output logic                 idex_stall,
   output logic                 idex_flush,
   output logic                 exmem_stall,
   output logic                 memwb_flush,
`ifdef PIPE_CTRL_PERF_CNT_EN
   output logic [31:0]          perf_lu_cycles,
   output logic [31:0]          perf_imiss_cycles,
   output logic [31:0]          perf_dmiss_cycles,
   output logic [31:0]          perf_redirects,
`endif
   output logic                 miss_timeout,
   output logic [PcStWidth-1:0] ctrl_state
);

   pc_state_e state_q, state_d;
   pc_state_e ret_q, ret_d;
   logic      kill_q, kill_d;

   logic freeze, redirect, load_use, fetch_bubble, kill_drop, lower_idle;

   // Priority decode: freeze > redirect > load-use > fetch bubble > stale-line drop.
   assign freeze       = (state_q == PcStDWait) | dcache_miss;
   assign redirect     = ~freeze & ex_redirect;
   assign lower_idle   = ~freeze & ~ex_redirect & ~hz_stall_req;
   assign load_use     = ~freeze & ~ex_redirect & hz_stall_req;
   assign fetch_bubble = lower_idle & (((state_q == PcStIWait) & ~icache_ready) |
                                       ((state_q == PcStRun) & icache_miss));
   assign kill_drop    = lower_idle & (state_q == PcStIWait) & icache_ready & kill_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= PcStRun;
         ret_q   <= PcStRun;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         kill_q  <= kill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      kill_d  = kill_q;
      case (state_q)
         PcStRun: begin
            if (dcache_miss) begin
               state_d = PcStDWait;
               ret_d   = PcStRun;
            end else if (icache_miss) begin
               state_d = PcStIWait;
               kill_d  = ex_redirect;
            end
         end
         PcStIWait: begin
            if (dcache_miss) begin
               state_d = PcStDWait;
               ret_d   = PcStIWait;
            end else if (icache_ready) begin
               state_d = PcStRun;
               kill_d  = 1'b0;
            end else if (ex_redirect) begin
               kill_d  = 1'b1;
            end
         end
         PcStDWait: begin
            if (dcache_ready) state_d = ret_q;
         end
         default: state_d = PcStRun;
      endcase
   end

   always_comb begin
      pc_stall       = 1'b0;
      pc_redirect_en = 1'b0;
      ifid_stall     = 1'b0;
      ifid_flush     = 1'b0;
      idex_stall     = 1'b0;
      idex_flush     = 1'b0;
      exmem_stall    = 1'b0;
      memwb_flush    = 1'b0;
      if (!rst_n) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else begin
         pc_stall       = freeze | load_use | fetch_bubble;
         pc_redirect_en = redirect;
         ifid_stall     = freeze | load_use;
         ifid_flush     = redirect | fetch_bubble | kill_drop;
         idex_stall     = freeze;
         idex_flush     = redirect | load_use;
         exmem_stall    = freeze;
         memwb_flush    = freeze;
      end
   end

   assign ctrl_state = state_q;

   pipe_ctrl_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_CNT_WIDTH   (TO_CNT_WIDTH)
   ) u_wdog (
      .clk          (clk),
      .rst_n        (rst_n),
      .active       (state_q != PcStRun),
      .miss_timeout (miss_timeout)
   );

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] lu_q, imiss_q, dmiss_q, redir_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lu_q    <= '0;
         imiss_q <= '0;
         dmiss_q <= '0;
         redir_q <= '0;
      end else begin
         lu_q    <= lu_q + {31'd0, load_use};
         imiss_q <= imiss_q + {31'd0, fetch_bubble};
         dmiss_q <= dmiss_q + {31'd0, freeze};
         redir_q <= redir_q + {31'd0, redirect};
      end
   end

   assign perf_lu_cycles    = lu_q;
   assign perf_imiss_cycles = imiss_q;
   assign perf_dmiss_cycles = dmiss_q;
   assign perf_redirects    = redir_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle comparison against a rule-level model plus literal checks.
module tb_pipe_ctrl;

   localparam int TO = 8;

   // Stimulus bit positions {hz, ex_redirect, icache_miss, icache_ready, dcache_miss, dcache_ready}
   localparam logic [5:0] H  = 6'b100000;
   localparam logic [5:0] E  = 6'b010000;
   localparam logic [5:0] IM = 6'b001000;
   localparam logic [5:0] IR = 6'b000100;
   localparam logic [5:0] DM = 6'b000010;
   localparam logic [5:0] DR = 6'b000001;

   typedef struct packed {
      logic       pc_stall;
      logic       redir;
      logic       ifid_stall;
      logic       ifid_flush;
      logic       idex_stall;
      logic       idex_flush;
      logic       exmem_stall;
      logic       memwb_flush;
      logic       to;
      logic [1:0] st;
   } outs_t;

   logic clk = 1'b0;
   logic rst_n, hz, exr, imiss, irdy, dmiss, drdy;
   logic pc_stall, pc_redirect_en, ifid_stall, ifid_flush, idex_stall, idex_flush;
   logic exmem_stall, memwb_flush, miss_timeout;
   logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] perf_lu, perf_im, perf_dm, perf_rd;
`endif

   int  vecs = 0;
   int  errs = 0;
   bit  checking = 1'b0;

   // Model state: mode 0=run, 1=waiting on I-cache, 2=waiting on D-cache
   int  m_st = 0, m_ret = 0, m_wait = 0;
   bit  m_kill = 1'b0, m_to = 1'b0;

   outs_t act;
   assign act = {pc_stall, pc_redirect_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
                 exmem_stall, memwb_flush, miss_timeout, ctrl_state};

   always #5 clk = ~clk;

   pipe_ctrl #(
      .TIMEOUT_CYCLES (TO),
      .TO_CNT_WIDTH   (4)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .hz_stall_req      (hz),
      .ex_redirect       (exr),
      .icache_miss       (imiss),
      .icache_ready      (irdy),
      .dcache_miss       (dmiss),
      .dcache_ready      (drdy),
      .pc_stall          (pc_stall),
      .pc_redirect_en    (pc_redirect_en),
      .ifid_stall        (ifid_stall),
      .ifid_flush        (ifid_flush),
      .idex_stall        (idex_stall),
      .idex_flush        (idex_flush),
      .exmem_stall       (exmem_stall),
      .memwb_flush       (memwb_flush),
`ifdef PIPE_CTRL_PERF_CNT_EN
      .perf_lu_cycles    (perf_lu),
      .perf_imiss_cycles (perf_im),
      .perf_dmiss_cycles (perf_dm),
      .perf_redirects    (perf_rd),
`endif
      .miss_timeout      (miss_timeout),
      .ctrl_state        (ctrl_state)
   );

   function automatic outs_t model_out();
      outs_t o;
      o    = '0;
      o.to = m_to;
      o.st = 2'(m_st);
      if (!rst_n) begin
         o.ifid_flush  = 1'b1;
         o.idex_flush  = 1'b1;
         o.memwb_flush = 1'b1;
      end else if (m_st == 2 || dmiss) begin
         o.pc_stall    = 1'b1;
         o.ifid_stall  = 1'b1;
         o.idex_stall  = 1'b1;
         o.exmem_stall = 1'b1;
         o.memwb_flush = 1'b1;
      end else if (exr) begin
         o.redir      = 1'b1;
         o.ifid_flush = 1'b1;
         o.idex_flush = 1'b1;
      end else if (hz) begin
         o.pc_stall   = 1'b1;
         o.ifid_stall = 1'b1;
         o.idex_flush = 1'b1;
      end else if ((m_st == 1 && !irdy) || (m_st == 0 && imiss)) begin
         o.pc_stall   = 1'b1;
         o.ifid_flush = 1'b1;
      end else if (m_st == 1 && m_kill) begin
         o.ifid_flush = 1'b1;
      end
      return o;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_st   <= 0;
         m_ret  <= 0;
         m_kill <= 1'b0;
         m_wait <= 0;
         m_to   <= 1'b0;
      end else begin
         if (m_st != 0) begin
            if (m_wait >= TO - 1) m_to <= 1'b1;
            m_wait <= m_wait + 1;
         end else begin
            m_wait <= 0;
         end
         if (m_st == 0) begin
            if (dmiss) begin
               m_st  <= 2;
               m_ret <= 0;
            end else if (imiss) begin
               m_st   <= 1;
               m_kill <= exr;
            end
         end else if (m_st == 1) begin
            if (dmiss) begin
               m_st  <= 2;
               m_ret <= 1;
            end else if (irdy) begin
               m_st   <= 0;
               m_kill <= 1'b0;
            end else if (exr) begin
               m_kill <= 1'b1;
            end
         end else if (drdy) begin
            m_st <= m_ret;
         end
      end
   end

   always @(negedge clk) begin
      outs_t e;
      if (checking) begin
         e = model_out();
         vecs++;
         if (act !== e) begin
            errs++;
            $display("FAIL cycle_compare t=%0t actual=%b required=%b", $time, act, e);
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
      vecs++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: actual=%0h required=%0h", name, got, want);
      end
   endtask

   // Advance to the next cycle, apply inputs, then settle mid-cycle for literal checks.
   task automatic cyc(input logic [5:0] v);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      {hz, exr, imiss, irdy, dmiss, drdy} = v;
      #2;
   endtask

   task automatic rcyc();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      {hz, exr, imiss, irdy, dmiss, drdy} = '0;
      #2;
   endtask

   initial begin
      rst_n = 1'b0;
      {hz, exr, imiss, irdy, dmiss, drdy} = '0;
      rcyc();
      checking = 1'b1;
      lit("reset_outputs", {ifid_flush, idex_flush, memwb_flush, pc_stall, exmem_stall,
                            pc_redirect_en}, 6'b111000);
      rcyc();

      // Load-use for one cycle
      cyc('0);
      cyc(H);
      lit("lu_outputs", {pc_stall, ifid_stall, idex_flush, ifid_flush}, 4'b1110);
      lit("lu_state", ctrl_state, 0);
      cyc('0);
      lit("lu_one_cycle", pc_stall, 0);

      // Redirect beats load-use
      cyc(H | E);
      lit("redir_over_lu", {pc_redirect_en, ifid_flush, idex_flush, pc_stall}, 4'b1110);

      // D-cache miss at 10, ready at 20; redirect/load-use held during freeze are ignored
      for (int i = 0; i <= 21; i++) begin
         cyc(i == 10 ? DM : i == 20 ? DR : (i >= 12 && i <= 14) ? (H | E) : 6'b0);
         if (i == 10 || i == 13 || i == 20)
            lit("freeze", {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush,
                           pc_redirect_en}, 6'b111110);
         if (i == 11) lit("dwait_state", ctrl_state, 2);
         if (i == 21) lit("dwait_release", {pc_stall, ifid_stall, idex_stall, exmem_stall,
                                            memwb_flush, ctrl_state}, 7'b0);
      end
      rcyc();

      // I-cache miss at 5, redirect at 7, ready at 12 with the stale line dropped
      for (int i = 0; i <= 13; i++) begin
         cyc(i == 5 ? IM : i == 7 ? E : i == 12 ? IR : 6'b0);
         if (i == 7) lit("imiss_redirect", pc_redirect_en, 1);
         if (i >= 5 && i <= 12) lit("imiss_ifid_flush", ifid_flush, 1);
         if (i == 13) lit("imiss_back_run", {ctrl_state, ifid_flush}, 0);
      end

      // Plain I-cache miss: no flush on the ready cycle
      cyc(IM);
      cyc('0);
      cyc(H);
      lit("lu_in_iwait", {ifid_flush, ifid_stall, idex_flush, ctrl_state}, 5'b01101);
      cyc(IR);
      lit("iready_no_kill", {ifid_flush, pc_stall, ctrl_state}, 4'b0001);
      cyc('0);
      lit("iready_exit", ctrl_state, 0);

      // I_WAIT -> D_WAIT -> I_WAIT -> RUN
      cyc(IM);
      cyc('0);
      cyc(DM);
      cyc('0);
      lit("iw_to_dw", ctrl_state, 2);
      cyc(DR);
      cyc(IR);
      lit("dw_back_iw", {ctrl_state, pc_stall, ifid_flush}, 4'b0100);
      cyc('0);
      lit("iw_exit_run", ctrl_state, 0);

      // Simultaneous misses return to RUN; redirect with a fetch miss arms the kill
      cyc(DM | IM);
      cyc('0);
      lit("both_miss_dwait", ctrl_state, 2);
      cyc(DR);
      cyc('0);
      lit("both_miss_run", ctrl_state, 0);
      cyc(IM | E);
      cyc('0);
      cyc(IR);
      lit("kill_from_run", {ifid_flush, pc_stall}, 2'b10);

      // Reset in the middle of a miss abandons it
      cyc(IM);
      cyc('0);
      rcyc();
      cyc('0);
      lit("reset_mid_miss", {ctrl_state, pc_stall}, 0);

      // Watchdog
      cyc(DM);
      for (int i = 1; i <= 20; i++) begin
         cyc(i == 20 ? DR : 6'b0);
         if (i == 8) lit("wdog_not_yet", miss_timeout, 0);
         if (i == 9) lit("wdog_fired", miss_timeout, 1);
      end
      cyc('0);
      cyc('0);
      lit("wdog_sticky", {miss_timeout, ctrl_state}, 3'b100);
      rcyc();
      cyc('0);
      lit("wdog_cleared", miss_timeout, 0);
      cyc('0);

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
